// File: rtl/ber_meter.sv
// Bit-error-rate meter: searches for the delay that aligns the received bit stream with
// the reference stream, locks to it, then counts compared bits and mismatches.
module ber_meter #(
    parameter int MAX_DELAY = 16,
    parameter int WIN_LEN   = 511,
    parameter int CNT_W     = 32,
    localparam int DW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sx,
    input  logic             dx,
    input  logic             clear,
    output logic             locked,
    output logic [DW-1:0]    delay_out,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             error_flag,
    output logic             saturated
);

    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int EW   = WC_W + 1;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [MAX_DELAY-2:0] line_reg;
    logic [MAX_DELAY-1:0] taps;
    logic [DW-1:0]        cand_reg;
    logic [DW-1:0]        best_delay_reg;
    logic [DW-1:0]        delay_reg;
    logic [WC_W-1:0]      win_cnt_reg;
    logic [EW-1:0]        cur_err_reg;
    logic [EW-1:0]        best_err_reg;
    logic [EW-1:0]        err_sum;
    logic [CNT_W-1:0]     bit_count_reg;
    logic [CNT_W-1:0]     err_count_reg;
    logic [CNT_W-1:0]     bit_count_inc;
    logic                 error_flag_reg;
    logic                 saturated_reg;
    logic                 strobe;
    logic                 search_mm;
    logic                 meas_mm;
    logic                 win_done;
    logic                 better;
    logic                 last_cand;
    logic                 go_lock;
    logic                 meas_strobe;
    logic                 at_max;

    // Tap 0 is the live reference bit, tap d is the bit seen d strobes ago.
    assign taps      = {line_reg, sx};
    assign strobe    = enable & ~clear;
    assign search_mm = dx ^ taps[cand_reg];
    assign meas_mm   = dx ^ taps[delay_reg];
    assign err_sum   = cur_err_reg + {{(EW-1){1'b0}}, search_mm};
    assign win_done  = strobe && (state_reg == SEARCH) && (win_cnt_reg == WC_W'(WIN_LEN - 1));
    assign better    = err_sum < best_err_reg;
    assign last_cand = cand_reg == DW'(MAX_DELAY - 1);
    assign go_lock   = win_done && ((err_sum == '0) || last_cand);

    assign meas_strobe   = strobe && (state_reg == MEASURE);
    assign at_max        = &bit_count_reg;
    assign bit_count_inc = bit_count_reg + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            line_reg <= '0;
        end else if (strobe) begin
            line_reg <= taps[MAX_DELAY-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SEARCH: begin
                if (!clear && go_lock) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (clear) begin
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        locked = (state_reg == MEASURE);
    end

    // Alignment search; a strictly better window keeps ties on the lower delay.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cand_reg       <= '0;
            win_cnt_reg    <= '0;
            cur_err_reg    <= '0;
            best_err_reg   <= '1;
            best_delay_reg <= '0;
            delay_reg      <= '0;
        end else if (strobe && (state_reg == SEARCH)) begin
            if (win_done) begin
                if (better) begin
                    best_err_reg   <= err_sum;
                    best_delay_reg <= cand_reg;
                end
                if (go_lock) begin
                    delay_reg <= better ? cand_reg : best_delay_reg;
                end else begin
                    cand_reg    <= cand_reg + DW'(1);
                    win_cnt_reg <= '0;
                    cur_err_reg <= '0;
                end
            end else begin
                win_cnt_reg <= win_cnt_reg + WC_W'(1);
                cur_err_reg <= err_sum;
            end
        end
    end

    // Measurement counters freeze once bit_count is all-ones; the error pulse keeps running.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_count_reg  <= '0;
            err_count_reg  <= '0;
            error_flag_reg <= 1'b0;
            saturated_reg  <= 1'b0;
        end else begin
            error_flag_reg <= meas_strobe & meas_mm;
            if (meas_strobe && !at_max) begin
                bit_count_reg <= bit_count_inc;
                err_count_reg <= err_count_reg + {{(CNT_W-1){1'b0}}, meas_mm};
                if (&bit_count_inc) begin
                    saturated_reg <= 1'b1;
                end
            end
        end
    end

    assign delay_out  = delay_reg;
    assign bit_count  = bit_count_reg;
    assign err_count  = err_count_reg;
    assign error_flag = error_flag_reg;
    assign saturated  = saturated_reg;

endmodule

// File: tb/tb_ber_meter.sv
// Randomized bench for ber_meter: PRBS9 traffic with chosen channel delays and error
// injection, checked every cycle against a window-scoring reference model.
module tb_ber_meter;

    localparam int MD   = 16;
    localparam int WIN  = 511;
    localparam int CW   = 10;
    localparam int DWT  = $clog2(MD);
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           sx;
    logic           dx;
    logic           clear;
    logic           locked;
    logic [DWT-1:0] delay_out;
    logic [CW-1:0]  bit_count;
    logic [CW-1:0]  err_count;
    logic           error_flag;
    logic           saturated;

    ber_meter #(.MAX_DELAY(MD), .WIN_LEN(WIN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sx(sx), .dx(dx), .clear(clear),
        .locked(locked), .delay_out(delay_out), .bit_count(bit_count),
        .err_count(err_count), .error_flag(error_flag), .saturated(saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: full sample history since rst, windows scored by direct summation.
    bit     sx_hist [0:65535];
    bit     dx_hist [0:65535];
    int     g;
    int     search_start;
    int     best_e;
    int     best_d;
    bit     m_locked;
    int     m_delay;
    longint m_bits;
    longint m_errs;
    bit     m_flag;
    bit     m_sat;

    int     lock_g;
    bit     prev_locked;
    int     pulses;
    logic [8:0] prbs;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit past_sx(input int i, input int k);
        return (i - k >= 0) ? sx_hist[i-k] : 1'b0;
    endfunction

    function automatic int window_errs(input int k, input int first);
        int e = 0;
        for (int i = first; i < first + WIN; i++) begin
            if (dx_hist[i] != past_sx(i, k)) e++;
        end
        return e;
    endfunction

    task automatic restart_model();
        search_start = g;
        best_e   = 1 << 30;
        best_d   = 0;
        m_locked = 1'b0;
        m_delay  = 0;
        m_bits   = 0;
        m_errs   = 0;
        m_sat    = 1'b0;
    endtask

    task automatic model_update(input bit en, input bit s, input bit d, input bit clr, input bit r);
        int rel, k, e;
        bit mm;
        m_flag = 1'b0;
        if (r) begin
            g = 0;
            restart_model();
        end else if (clr) begin
            restart_model();
        end else if (en) begin
            sx_hist[g] = s;
            dx_hist[g] = d;
            if (!m_locked) begin
                rel = g - search_start;
                if ((rel + 1) % WIN == 0) begin
                    k = rel / WIN;
                    e = window_errs(k, search_start + k * WIN);
                    if (e < best_e) begin
                        best_e = e;
                        best_d = k;
                    end
                    if (e == 0) begin
                        m_locked = 1'b1;
                        m_delay  = k;
                    end else if (k == MD - 1) begin
                        m_locked = 1'b1;
                        m_delay  = best_d;
                    end
                end
            end else begin
                mm     = (d != past_sx(g, m_delay));
                m_flag = mm;
                if (m_bits < CMAX) begin
                    m_bits++;
                    m_errs += mm;
                end
                m_sat = (m_bits == CMAX);
            end
            g++;
        end
    endtask

    task automatic compare_outputs();
        check_eq("locked", longint'(locked), longint'(m_locked));
        check_eq("bit_count", longint'(bit_count), m_bits);
        check_eq("err_count", longint'(err_count), m_errs);
        check_eq("error_flag", longint'(error_flag), longint'(m_flag));
        check_eq("saturated", longint'(saturated), longint'(m_sat));
        if (m_locked) check_eq("delay_out", longint'(delay_out), longint'(m_delay));
        if (locked === 1'b1 && !prev_locked) lock_g = g;
        if (error_flag === 1'b1) pulses++;
        prev_locked = (locked === 1'b1);
    endtask

    task automatic step(input bit en, input bit s, input bit d, input bit clr, input bit r);
        enable = en; sx = s; dx = d; clear = clr; rst = r;
        @(posedge clk);
        #1;
        model_update(en, s, d, clr, r);
        enable = 1'b0; clear = 1'b0; rst = 1'b0;
        compare_outputs();
    endtask

    function automatic bit prbs_next();
        bit b;
        b    = prbs[8];
        prbs = {prbs[7:0], prbs[8] ^ prbs[4]};
        return b;
    endfunction

    // One strobe of traffic: dx is the reference delayed by dly, optionally corrupted.
    task automatic strobe_traffic(input int dly, input int inj, input bit zero, input int rate,
                                  input bit clr);
        bit s, d;
        if ($urandom_range(0, 7) == 0) step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        s = prbs_next();
        d = (dly == 0) ? s : past_sx(g, dly);
        if (inj > 0 && (g % inj) == inj - 1) d = ~d;
        if (rate > 0 && $urandom_range(0, 99) < rate) d = ~d;
        if (zero) d = 1'b0;
        step(1'b1, s, d, clr, 1'b0);
    endtask

    task automatic run(input int n, input int dly, input int inj, input bit zero, input int rate,
                       input bit until_lock);
        int cnt = 0;
        while (cnt < n && !(until_lock && m_locked)) begin
            strobe_traffic(dly, inj, zero, rate, 1'b0);
            cnt++;
        end
        if (until_lock) check_eq("lock_reached", longint'(locked), 1);
    endtask

    task automatic do_reset();
        prbs = 9'h1AA;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        lock_g = -1;
        pulses = 0;
    endtask

    int     clr_g;
    int     rd;
    longint errs_before;

    initial begin
        rst = 1'b0; enable = 1'b0; sx = 1'b0; dx = 1'b0; clear = 1'b0;
        g = 0; prev_locked = 1'b0;
        restart_model();
        repeat (2) @(posedge clk);

        do_reset();
        check_eq("rst_locked", longint'(locked), 0);
        check_eq("rst_delay", longint'(delay_out), 0);
        check_eq("rst_bits", longint'(bit_count), 0);
        $display("reset: locked=%0d bit_count=%0d", locked, bit_count);

        run(MD * WIN + 8, 5, 0, 1'b0, 0, 1'b1);
        check_eq("d5_lock_time", lock_g, 6 * WIN);
        run(300, 5, 0, 1'b0, 0, 1'b0);
        check_eq("d5_delay", longint'(delay_out), 5);
        check_eq("d5_errs", longint'(err_count), 0);
        $display("delay5: lock at strobe %0d delay_out=%0d bits=%0d errs=%0d",
                 lock_g, delay_out, bit_count, err_count);

        clr_g = g;
        strobe_traffic(5, 0, 1'b0, 0, 1'b1);
        check_eq("clr_locked", longint'(locked), 0);
        check_eq("clr_bits", longint'(bit_count), 0);
        check_eq("clr_errs", longint'(err_count), 0);
        run(MD * WIN + 8, 5, 0, 1'b0, 0, 1'b1);
        check_eq("relock_time", lock_g - clr_g, 6 * WIN);
        check_eq("relock_delay", longint'(delay_out), 5);
        $display("clear+enable: relock after %0d strobes delay_out=%0d", lock_g - clr_g, delay_out);

        do_reset();
        run(MD * WIN + 8, 3, 100, 1'b0, 0, 1'b1);
        check_eq("d3_lock_time", lock_g, MD * WIN);
        check_eq("d3_delay", longint'(delay_out), 3);
        pulses = 0;
        run(1000, 3, 100, 1'b0, 0, 1'b0);
        check_eq("d3_bits", longint'(bit_count), 1000);
        check_eq("d3_errs", longint'(err_count), 10);
        check_eq("d3_pulses", pulses, 10);
        $display("delay3+inject: delay_out=%0d bits=%0d errs=%0d pulses=%0d",
                 delay_out, bit_count, err_count, pulses);

        do_reset();
        run(MD * WIN + 8, 0, 0, 1'b1, 0, 1'b1);
        check_eq("zero_lock_time", lock_g, MD * WIN);
        check_eq("zero_delay", longint'(delay_out), 0);
        $display("dx=0 tie: lock at strobe %0d delay_out=%0d", lock_g, delay_out);

        do_reset();
        run(MD * WIN + 8, 0, 0, 1'b0, 0, 1'b1);
        check_eq("d0_lock_time", lock_g, WIN);
        run(int'(CMAX) + 20, 0, 0, 1'b0, 0, 1'b0);
        check_eq("sat_bits", longint'(bit_count), CMAX);
        check_eq("sat_flag_set", longint'(saturated), 1);
        errs_before = m_errs;
        begin
            bit s;
            s = prbs_next();
            step(1'b1, s, ~s, 1'b0, 1'b0);
        end
        check_eq("sat_err_pulse", longint'(error_flag), 1);
        check_eq("sat_err_hold", longint'(err_count), errs_before);
        $display("saturation: bits=%0d saturated=%0d errs=%0d", bit_count, saturated, err_count);

        do_reset();
        run(7 * WIN + 100, 9, 0, 1'b0, 0, 1'b0);
        check_eq("mid_not_locked", longint'(locked), 0);
        begin
            bit s;
            s = prbs_next();
            step(1'b1, s, 1'b1, 1'b1, 1'b1);
        end
        check_eq("mid_rst_locked", longint'(locked), 0);
        check_eq("mid_rst_delay", longint'(delay_out), 0);
        prbs = 9'h1AA;
        lock_g = -1;
        run(MD * WIN + 8, 9, 0, 1'b0, 0, 1'b1);
        check_eq("mid_lock_time", lock_g, 10 * WIN);
        check_eq("mid_delay", longint'(delay_out), 9);
        $display("rst mid-search: relock at strobe %0d delay_out=%0d", lock_g, delay_out);

        do_reset();
        rd = $urandom_range(0, MD - 1);
        run(MD * WIN + 8, rd, 0, 1'b0, $urandom_range(0, 3), 1'b1);
        run(500, rd, 0, 1'b0, 2, 1'b0);
        $display("random: channel delay %0d -> delay_out=%0d bits=%0d errs=%0d",
                 rd, delay_out, bit_count, err_count);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
